// File: rtl/aline_fire_sequencer.sv
// aline_fire_sequencer: sequences one image acquisition, one delay read and one delayed pulse burst per A-line
// Ports: clk/rst (sync, active-high); start/abort control; intaking_configs/updating_delays handshake with the
// config store; channel_select, aline_select, pulse_shape, ch_delays configuration; rd_en/which_aline delay
// read request; tx_out transmit bits; busy, fire_active, done, err_timeout status.
// Build option FIRE_TRIGGER_EN: adds input trig and an ARM state that holds FIRE until a trig rising edge.
module aline_fire_sequencer #(
  parameter int          PULSE_LEN  = 32,
  parameter logic [15:0] GAP_CYCLES = 16'd1000,
  parameter logic [7:0]  RD_TIMEOUT = 8'd64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 intaking_configs,
  input  logic                 updating_delays,
  input  logic [7:0]           channel_select,
  input  logic [4:0]           aline_select,
  input  logic [PULSE_LEN-1:0] pulse_shape,
  input  logic [127:0]         ch_delays,
`ifdef FIRE_TRIGGER_EN
  input  logic                 trig,
`endif
  output logic                 rd_en,
  output logic [3:0]           which_aline,
  output logic [7:0]           tx_out,
  output logic                 busy,
  output logic                 fire_active,
  output logic                 done,
  output logic                 err_timeout
);
  localparam int PW = PULSE_LEN > 1 ? $clog2(PULSE_LEN) : 1;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WUP  = 3'd2;
  localparam logic [2:0] S_WDN  = 3'd3;
  localparam logic [2:0] S_FIRE = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;
`ifdef FIRE_TRIGGER_EN
  localparam logic [2:0] S_ARM  = 3'd6;
  localparam logic [2:0] S_DN_NXT = S_ARM;
`else
  localparam logic [2:0] S_DN_NXT = S_FIRE;
`endif
  logic [2:0]   r_state, w_nxt;
  logic [4:0]   r_n, w_n;
  logic [3:0]   r_idx;
  logic [15:0]  r_tmr, w_max;
  logic [16:0]  r_cnt, w_end;
  logic [127:0] r_d;
  logic [7:0]   r_en, r_tx, w_tx;
  logic         r_rd_en, r_done, r_err;
  logic         w_abort, w_go, w_tmo, w_gap_end, w_last, w_fire_end, w_trig_edge;
  // intaking_configs mid-run behaves exactly like abort; in IDLE it only blocks start
  assign w_abort    = abort | intaking_configs;
  assign w_go       = r_state == S_IDLE && start && !w_abort;
  assign w_n        = aline_select > 5'd16 ? 5'd16 : aline_select;
  // r_tmr restarts on every state change, so it measures time spent in the current state
  assign w_tmo      = r_tmr + 16'd1 >= {8'd0, RD_TIMEOUT};
  assign w_gap_end  = r_tmr + 16'd1 >= GAP_CYCLES;
  assign w_last     = {1'b0, r_idx} + 5'd1 >= r_n;
  // fire length is set by the latest enabled channel only; 17 bits so a 16'hFFFF delay cannot wrap
  assign w_end      = {1'b0, w_max} + 17'(PULSE_LEN);
  assign w_fire_end = ~|r_en || r_cnt + 17'd1 == w_end;
`ifdef FIRE_TRIGGER_EN
  logic r_trig, r_trig_d;
  always_ff @(posedge clk) begin
    if (rst) {r_trig, r_trig_d} <= 2'b00;
    else {r_trig, r_trig_d} <= {trig, r_trig};
  end
  assign w_trig_edge = r_trig && !r_trig_d;
`else
  assign w_trig_edge = 1'b0;
`endif
  always_comb begin
    w_max = '0;
    for (int c = 0; c < 8; c++) if (r_en[c] && r_d[16*c +: 16] > w_max) w_max = r_d[16*c +: 16];
  end
  for (genvar c = 0; c < 8; c++) begin : g_ch
    logic [16:0] w_dc, w_off;
    assign w_dc    = {1'b0, r_d[16*c +: 16]};
    assign w_off   = r_cnt - w_dc;
    assign w_tx[c] = r_en[c] && r_cnt >= w_dc && w_off < 17'(PULSE_LEN) && pulse_shape[PW'(PULSE_LEN - 1) - w_off[PW-1:0]];
  end
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  w_nxt = w_go && w_n != 5'd0 ? S_REQ : S_IDLE;
      S_REQ:   w_nxt = S_WUP;
      S_WUP:   w_nxt = updating_delays ? S_WDN : w_tmo ? S_IDLE : S_WUP;
      S_WDN:   w_nxt = updating_delays ? S_WDN : S_DN_NXT;
`ifdef FIRE_TRIGGER_EN
      S_ARM:   w_nxt = w_trig_edge ? S_FIRE : S_ARM;
`endif
      S_FIRE:  w_nxt = w_fire_end ? S_GAP : S_FIRE;
      S_GAP:   w_nxt = !w_gap_end ? S_GAP : w_last ? S_IDLE : S_REQ;
      default: w_nxt = S_IDLE;
    endcase
    if (w_abort) w_nxt = S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_cnt   <= '0;
      r_n     <= '0;
      r_idx   <= '0;
      r_d     <= '0;
      r_en    <= '0;
      r_tx    <= '0;
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_tmr   <= w_nxt != r_state ? '0 : r_tmr + 16'd1;
      r_cnt   <= r_state == S_FIRE ? r_cnt + 17'd1 : '0;
      r_rd_en <= w_nxt == S_REQ;
      r_done  <= !w_abort && ((w_go && w_n == 5'd0) || (r_state == S_GAP && w_gap_end && w_last));
      r_tx    <= r_state == S_FIRE && !w_abort ? w_tx : '0;
      r_err   <= w_go ? 1'b0 : r_err | (r_state == S_WUP && !updating_delays && w_tmo && !w_abort);
      if (w_go) begin
        r_n   <= w_n;
        r_idx <= '0;
      end else if (r_state == S_GAP && w_nxt == S_REQ) r_idx <= r_idx + 4'd1;
      if (r_state == S_WDN && !updating_delays) begin
        r_d  <= ch_delays;
        r_en <= channel_select;
      end
    end
  end
  assign rd_en       = r_rd_en;
  assign which_aline = r_idx;
  assign tx_out      = r_tx;
  assign busy        = r_state != S_IDLE;
  assign fire_active = r_state == S_FIRE;
  assign done        = r_done;
  assign err_timeout = r_err;
endmodule

// File: tb/tb_aline_fire_sequencer.sv
// tb_aline_fire_sequencer: directed plus randomized image runs checked against a cycle-level arithmetic model
module tb_aline_fire_sequencer;
  localparam int          PL  = 32;
  localparam logic [15:0] GAP = 16'd20;
  localparam int          RTO = 64;
  logic clk = 1'b0, rst, start, abort, intaking_configs, updating_delays;
  logic [7:0] channel_select, tx_out;
  logic [4:0] aline_select;
  logic [PL-1:0] pulse_shape;
  logic [127:0] ch_delays;
  logic rd_en, busy, fire_active, done, err_timeout;
  logic [3:0] which_aline;
`ifdef FIRE_TRIGGER_EN
  logic trig = 1'b0;
`endif
  int vectors = 0, miscompares = 0, rd_cnt = 0, done_cnt = 0;
  int m_d[8];
  logic [7:0] m_en;
  logic [31:0] m_ps;
  always #5 clk = ~clk;
  aline_fire_sequencer #(.PULSE_LEN(PL), .GAP_CYCLES(GAP), .RD_TIMEOUT(8'(RTO))) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .intaking_configs(intaking_configs),
    .updating_delays(updating_delays), .channel_select(channel_select), .aline_select(aline_select),
    .pulse_shape(pulse_shape), .ch_delays(ch_delays),
`ifdef FIRE_TRIGGER_EN
    .trig(trig),
`endif
    .rd_en(rd_en), .which_aline(which_aline), .tx_out(tx_out), .busy(busy),
    .fire_active(fire_active), .done(done), .err_timeout(err_timeout)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (rd_en === 1'b1) rd_cnt++;
    if (done === 1'b1) done_cnt++;
  endtask
  function automatic int m_len();
    int mx = 0;
    if (m_en == 8'd0) return 1;
    for (int c = 0; c < 8; c++) if (m_en[c] && m_d[c] > mx) mx = m_d[c];
    return mx + PL;
  endfunction
  // t counts sample points from the first cycle fire_active is seen; tx reflects counter value t-1
  function automatic logic [7:0] m_tx(int t);
    logic [7:0] r = '0;
    int k = t - 1;
    if (k < 0 || k >= m_len()) return r;
    for (int c = 0; c < 8; c++) if (m_en[c] && k >= m_d[c] && k - m_d[c] < PL) r[c] = m_ps[PL-1-(k-m_d[c])];
    return r;
  endfunction
  task automatic drive();
    channel_select = m_en;
    pulse_shape = m_ps;
    for (int c = 0; c < 8; c++) ch_delays[16*c +: 16] = 16'(m_d[c]);
  endtask
  task automatic wait_rd();
    int i = 0;
    while (rd_en !== 1'b1 && i < 3 * GAP + 100) begin tick(); i++; end
    chk("rd_en_seen", rd_en, 1);
  endtask
  task automatic wait_fa();
    int i = 0;
    while (fire_active !== 1'b1 && i < 40) begin tick(); i++; end
    chk("fire_seen", fire_active, 1);
  endtask
  task automatic wait_idle();
    int i = 0;
    while (busy !== 1'b0 && i < 3 * GAP + 100) begin tick(); i++; end
    chk("idle_seen", busy, 0);
  endtask
  task automatic respond();
    repeat ($urandom_range(5, 1)) tick();
    updating_delays = 1'b1;
    repeat ($urandom_range(4, 1)) tick();
    updating_delays = 1'b0;
`ifdef FIRE_TRIGGER_EN
    repeat (4) begin tick(); chk("arm_hold", {fire_active, tx_out}, 0); end
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    chk("trig_fire", fire_active, 1);
`endif
  endtask
  task automatic trace(bit chaos);
    int len = m_len();
    int fa = 0;
    for (int t = 0; t <= len + 1; t++) begin
      chk("tx_out", tx_out, m_tx(t));
      chk("fire_active", fire_active, t < len);
      if (fire_active === 1'b1) fa++;
      if (chaos && t == 2) begin
        channel_select = ~m_en;
        ch_delays = {$urandom, $urandom, $urandom, $urandom};
      end
      if (t <= len) tick();
    end
    drive();
    chk("fire_len", fa, len);
  endtask
  task automatic run_image(int sel, bit chaos);
    int n = sel > 16 ? 16 : sel;
    aline_select = 5'(sel);
    rd_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_clear", err_timeout, 0);
    for (int k = 0; k < n; k++) begin
      wait_rd();
      chk("which_aline", which_aline, k);
      respond();
      wait_fa();
      trace(chaos);
    end
    wait_idle();
    chk("done_at_end", done, 1);
    repeat (2) tick();
    chk("done_count", done_cnt, 1);
    chk("rd_count", rd_cnt, n);
  endtask
  task automatic abort_run(bit intake);
    m_en = 8'hFF;
    m_ps = 32'hFFFF_FFFF;
    for (int c = 0; c < 8; c++) m_d[c] = 0;
    drive();
    aline_select = 5'd2;
    rd_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_rd();
    respond();
    wait_fa();
    repeat (8) tick();
    chk("pre_abort_tx", tx_out, m_tx(8));
    if (intake) intaking_configs = 1'b1;
    else abort = 1'b1;
    tick();
    abort = 1'b0;
    intaking_configs = 1'b0;
    chk("abort_tx", tx_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_fire", fire_active, 0);
    repeat (GAP + 60) tick();
    chk("abort_done", done_cnt, 0);
    chk("abort_rd", rd_cnt, 1);
  endtask
  initial begin
    rst = 1'b1;
    {start, abort, intaking_configs, updating_delays} = 4'b0;
    aline_select = 5'd0;
    m_en = 8'h00;
    m_ps = 32'h0;
    for (int c = 0; c < 8; c++) m_d[c] = 0;
    drive();
    repeat (2) tick();
    chk("rst_tx", tx_out, 0);
    chk("rst_rd", rd_en, 0);
    chk("rst_which", which_aline, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fire", fire_active, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_timeout, 0);
    rst = 1'b0;
    tick();
    m_en = 8'h01;
    m_ps = 32'h8000_0001;
    m_d[0] = 5;
    m_d[1] = 16'hFFF0;
    for (int c = 2; c < 8; c++) m_d[c] = int'($urandom_range(200, 0));
    drive();
    run_image(2, 1'b0);
    m_en = 8'hFF;
    m_ps = 32'hFFFF_FFFF;
    for (int c = 0; c < 8; c++) m_d[c] = 10 * c;
    drive();
    run_image(1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      m_en = 8'($urandom);
      m_ps = $urandom;
      for (int c = 0; c < 8; c++) m_d[c] = int'($urandom_range(60, 0));
      drive();
      run_image(int'($urandom_range(3, 1)), i[0]);
    end
    aline_select = 5'd1;
    rd_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (RTO) tick();
    chk("tmo_busy_before", busy, 1);
    chk("tmo_err_before", err_timeout, 0);
    tick();
    chk("tmo_busy", busy, 0);
    chk("tmo_err", err_timeout, 1);
    repeat (5) tick();
    chk("tmo_done", done_cnt, 0);
    chk("tmo_rd", rd_cnt, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("err_sticky_abort", err_timeout, 1);
    aline_select = 5'd0;
    rd_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_err_clear", err_timeout, 0);
    tick();
    chk("zero_done_end", done, 0);
    repeat (3) tick();
    chk("zero_rd", rd_cnt, 0);
    chk("zero_done_count", done_cnt, 1);
    intaking_configs = 1'b1;
    aline_select = 5'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("intake_busy", busy, 0);
    tick();
    chk("intake_busy2", busy, 0);
    intaking_configs = 1'b0;
    chk("intake_rd", rd_cnt, 0);
    abort_run(1'b0);
    abort_run(1'b1);
    m_en = 8'h00;
    drive();
    run_image(20, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/aline_fire_sequencer.md
Name: aline_fire_sequencer

Overview:
Sequences one full image acquisition from the stored image configuration. For each A-line it requests that A-line's eight channel delays from the configuration store. It then fires the pulse_shape waveform on every enabled channel, each offset by its own delay. It sits between the host-facing configuration block and the transducer transmit pins, and is the only source of rd_en and which_aline to the configuration store.

Parameters:
PULSE_LEN, 32, number of pulse_shape bits emitted per channel per A-line, MSB first
GAP_CYCLES, 16'd1000, idle cycles between the end of one A-line fire and the next delay request
RD_TIMEOUT, 8'd64, maximum cycles to wait for updating_delays to rise after rd_en

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin an image
abort  in  1  stop the image immediately
intaking_configs  in  1  configuration load in progress; start is ignored while high
updating_delays  in  1  configuration store is loading delay registers
channel_select  in  8  per-channel transmit enable
aline_select  in  5  number of A-lines in the image
pulse_shape  in  PULSE_LEN  transmit bit pattern
ch_delays  in  128  {ch7delay, ..., ch0delay}, each 16 bits, unsigned cycles
rd_en  out  1  single-cycle delay-read request to the configuration store
which_aline  out  4  A-line index whose delays are requested
tx_out  out  8  per-channel transmit bit
busy  out  1  high in every state except IDLE
fire_active  out  1  high during FIRE
done  out  1  one-cycle pulse when an image completes normally
err_timeout  out  1  sticky; set on read timeout, cleared by start or rst

Behaviour:
- Reset: state IDLE; tx_out=0, rd_en=0, which_aline=0, busy=0, fire_active=0, done=0, err_timeout=0; internal counters zeroed.
- All state and outputs are registered on posedge clk. tx_out lags the fire counter by one cycle.
- IDLE:
  - On start & ~intaking_configs: latch n = min(aline_select, 16), clear err_timeout, set idx=0.
  - If n==0, pulse done and stay in IDLE; otherwise go to REQ.
- REQ: drive which_aline=idx and rd_en=1 for exactly one cycle, then go to WAIT_UP.
- WAIT_UP:
  - Go to WAIT_DN when updating_delays=1.
  - After RD_TIMEOUT cycles without that: set err_timeout and go to IDLE with no done pulse.
- WAIT_DN: when updating_delays=0, latch ch_delays and channel_select into local registers, clear the 17-bit fire counter, and go to FIRE.
- FIRE:
  - fire_active=1.
  - Per channel c, next tx_out[c] = en[c] & (cnt >= d[c]) & (cnt - d[c] < PULSE_LEN) ? pulse_shape[PULSE_LEN-1-(cnt-d[c])] : 0.
  - cnt increments every cycle. Fire ends when cnt == max(d[c] over enabled c) + PULSE_LEN.
  - If no channel is enabled, FIRE lasts exactly one cycle.
  - Go to GAP on exit; tx_out is 0 from then on.
- GAP:
  - Count GAP_CYCLES.
  - If idx == n-1: pulse done and go to IDLE.
  - Otherwise idx++ and go to REQ.
- abort (any state): next cycle state=IDLE and tx_out=0; no done pulse; err_timeout is unaffected.
- start while busy is ignored. A change of channel_select or ch_delays during FIRE has no effect until the next WAIT_DN latch.
- The delay of 16'hFFFF is legal: the counter is 17 bits wide, so there is no wrap.
- rd_en is never asserted while intaking_configs=1. If intaking_configs rises during a run, behave as abort.

Optional Feature:
FIRE_TRIGGER_EN:
- Defined: adds input trig (1 bit). WAIT_DN exits to a new ARM state instead of FIRE. ARM waits for a rising edge on trig (registered, edge-detected) and then enters FIRE on the next cycle. abort still applies in ARM; busy=1 in ARM.
- Undefined: no trig port and no ARM state; WAIT_DN goes directly to FIRE.

Test Plan:
- Basic image:
  - Stimulus: aline_select=2, channel_select=8'h01, pulse_shape=32'h8000_0001, ch0 delay=5.
  - Required: rd_en pulses with which_aline=0, then 1.
  - Required per A-line: tx_out[0] high exactly at fire cycles 6 and 37 (cnt 5 and 36 plus one-cycle latency).
  - Required: done pulses once after the second GAP.
- Staggered delays:
  - Stimulus: all 8 channels enabled, delays 0,10,...,70, pulse_shape=32'hFFFF_FFFF.
  - Required: each tx_out[c] is high for 32 cycles starting at 10c+1; fire_active lasts 102 cycles.
- Read timeout: updating_delays held at 0 -> err_timeout=1 and busy=0 after RD_TIMEOUT+2 cycles; done stays 0.
- Abort and ignored start:
  - Stimulus: abort asserted mid-FIRE -> tx_out=0 and state IDLE on the next cycle; done stays 0.
  - Stimulus: start during intaking_configs=1 -> busy stays 0.
- Edge counts:
  - Stimulus: aline_select=0 -> one-cycle done, no rd_en.
  - Stimulus: aline_select=20 -> exactly 16 rd_en pulses, with which_aline running 0..15.
- Trigger (FIRE_TRIGGER_EN defined): no trig edge -> no tx_out activity; trig edge -> FIRE starts on the next cycle.
